// File: rtl/approx_madd_pkg.sv
// Shared types and helpers for the approximate multiply-add pipeline.
// Widths are passed in explicitly so the helpers serve any parameterisation.
package approx_madd_pkg;

   localparam int W_DEF     = 6;
   localparam int OUT_W_DEF = 2 * W_DEF;
   localparam int MASK_W    = 64;
   localparam int SAT_W     = MASK_W + 1;

   function automatic int tw_of(input int out_w);
      return $clog2(out_w + 1);
   endfunction

   localparam int TW_DEF = tw_of(OUT_W_DEF);

   // Ones in columns [out_w-1:t]; callers cast down to their result width.
   function automatic logic [MASK_W-1:0] col_mask(input int t, input int out_w);
      logic [MASK_W-1:0] m;
      for (int k = 0; k < MASK_W; k++) begin
         m[k] = (k >= t) && (k < out_w);
      end
      return m;
   endfunction

   function automatic logic [MASK_W-1:0] sat_add(input logic [MASK_W-1:0] x,
                                                 input logic [MASK_W-1:0] y,
                                                 input int                width);
      logic [SAT_W-1:0] s;
      logic [SAT_W-1:0] lim;
      s   = {1'b0, x} + {1'b0, y};
      lim = (SAT_W'(1) << width) - SAT_W'(1);
      return (s > lim) ? lim[MASK_W-1:0] : s[MASK_W-1:0];
   endfunction

   typedef struct packed {
      logic [W_DEF-1:0]  a;
      logic [W_DEF-1:0]  b;
      logic [W_DEF-1:0]  c;
      logic [TW_DEF-1:0] t;
   } beat_t;

endpackage

// File: rtl/approx_madd_core.sv
// Masked partial-product summer: adds a[i]&b[j] at column i+j only when i+j >= t.
// Dropped columns contribute neither bits nor carries.
module approx_madd_core
   import approx_madd_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int OUT_W = 2 * W,
   parameter int TW    = tw_of(OUT_W)
) (
   input  logic [W-1:0]     a_i,
   input  logic [W-1:0]     b_i,
   input  logic [TW-1:0]    t_i,
   output logic [OUT_W-1:0] sum_o
);

   logic [OUT_W-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = 0; i < W; i++) begin
         for (int j = 0; j < W; j++) begin
            if (((i + j) >= int'(t_i)) && ((i + j) < OUT_W) && a_i[i] && b_i[j]) begin
               acc = acc + (OUT_W'(1) << (i + j));
            end
         end
      end
   end

   assign sum_o = acc;

endmodule

// File: rtl/approx_madd_pipe.sv
// Two-stage valid/ready approximate multiply-add: res = a*b + c with runtime column truncation.
// Define APPROX_MADD_ERR_MON_EN to add the exact-result path and |exact-approx| error monitor.
module approx_madd_pipe
   import approx_madd_pkg::*;
#(
   parameter int W         = W_DEF,
   parameter int OUT_W     = 2 * W,
   parameter int TRUNC_MAX = OUT_W,
   parameter int TW        = tw_of(OUT_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_a,
   input  logic [W-1:0]       in_b,
   input  logic [W-1:0]       in_c,
   input  logic [TW-1:0]      in_trunc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   out_res,
   input  logic               err_clr,
   output logic [2*OUT_W-1:0] err_sum,
   output logic [OUT_W-1:0]   err_max,
   output logic [15:0]        err_cnt
);

   localparam int            EW    = 2 * OUT_W;
   localparam logic [TW-1:0] T_LIM = TW'(TRUNC_MAX);

   // Same layout as beat_t, sized to this instance's parameters.
   typedef struct packed {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [W-1:0]  c;
      logic [TW-1:0] t;
   } stage1_t;

   stage1_t          s1_q, s1_d;
   logic             s1_v_q, s1_v_d;
   logic             out_v_q, out_v_d;
   logic [OUT_W-1:0] res_q, res_d;
   logic             in_fire, s1_adv, retire;
   logic [OUT_W-1:0] pp_sum, c_masked;

   assign s1_adv   = s1_v_q & (~out_v_q | out_ready);
   assign in_ready = ~s1_v_q | s1_adv;
   assign in_fire  = in_valid & in_ready;
   assign retire   = out_v_q & out_ready;

   approx_madd_core #(.W(W), .OUT_W(OUT_W), .TW(TW)) u_core (
      .a_i   (s1_q.a),
      .b_i   (s1_q.b),
      .t_i   (s1_q.t),
      .sum_o (pp_sum)
   );

   assign c_masked = OUT_W'(s1_q.c) & OUT_W'(col_mask(int'(s1_q.t), OUT_W));

   always_comb begin
      s1_d    = s1_q;
      s1_v_d  = s1_v_q;
      out_v_d = out_v_q;
      res_d   = res_q;
      if (in_fire) begin
         s1_d.a = in_a;
         s1_d.b = in_b;
         s1_d.c = in_c;
         s1_d.t = (in_trunc > T_LIM) ? T_LIM : in_trunc;
         s1_v_d = 1'b1;
      end else if (s1_adv) begin
         s1_v_d = 1'b0;
      end
      if (s1_adv) begin
         out_v_d = 1'b1;
         res_d   = pp_sum + c_masked;
      end else if (retire) begin
         out_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q    <= '0;
         s1_v_q  <= 1'b0;
         out_v_q <= 1'b0;
         res_q   <= '0;
      end else begin
         s1_q    <= s1_d;
         s1_v_q  <= s1_v_d;
         out_v_q <= out_v_d;
         res_q   <= res_d;
      end
   end

   assign out_valid = out_v_q;
   assign out_res   = res_q;

`ifdef APPROX_MADD_ERR_MON_EN
   logic [OUT_W-1:0] exact_pp;
   logic [OUT_W-1:0] exact_q, exact_d;
   logic [OUT_W-1:0] err_abs;
   logic [EW-1:0]    sum_q, sum_d;
   logic [OUT_W-1:0] max_q, max_d;
   logic [15:0]      cnt_q, cnt_d;

   approx_madd_core #(.W(W), .OUT_W(OUT_W), .TW(TW)) u_core_exact (
      .a_i   (s1_q.a),
      .b_i   (s1_q.b),
      .t_i   ('0),
      .sum_o (exact_pp)
   );

   // The exact result travels alongside res_q so both describe the same beat at retire.
   assign err_abs = (exact_q >= res_q) ? (exact_q - res_q) : (res_q - exact_q);

   always_comb begin
      exact_d = exact_q;
      sum_d   = sum_q;
      max_d   = max_q;
      cnt_d   = cnt_q;
      if (s1_adv) begin
         exact_d = exact_pp + OUT_W'(s1_q.c);
      end
      if (err_clr) begin
         sum_d = '0;
         max_d = '0;
         cnt_d = '0;
      end else if (retire) begin
         sum_d = EW'(sat_add(MASK_W'(sum_q), MASK_W'(err_abs), EW));
         max_d = (err_abs > max_q) ? err_abs : max_q;
         cnt_d = 16'(sat_add(MASK_W'(cnt_q), MASK_W'(1), 16));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exact_q <= '0;
         sum_q   <= '0;
         max_q   <= '0;
         cnt_q   <= '0;
      end else begin
         exact_q <= exact_d;
         sum_q   <= sum_d;
         max_q   <= max_d;
         cnt_q   <= cnt_d;
      end
   end

   assign err_sum = sum_q;
   assign err_max = max_q;
   assign err_cnt = cnt_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
   assign err_sum        = '0;
   assign err_max        = '0;
   assign err_cnt        = '0;
`endif

endmodule
